// File: rtl/ca_mem_arb.sv
// Cache/data memory port arbiter: one shared port, fill vs load/store.
// Define CA_MEM_ARB_RR_EN for round-robin; default is fixed DATA priority.
module ca_mem_arb #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              flush,
  input  logic              dat_req,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dat_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_done,
  output logic              dat_done,
  output logic              fill_stall,
  output logic              dat_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       fill_v;
  logic       grant_dat;
  logic       grant_fill;

  assign last   = (cnt == LAST);
  assign fill_v = fill_req & ~flush;

`ifdef CA_MEM_ARB_RR_EN
  logic ptr_fill;

  always_comb begin
    grant_dat  = dat_req & (~fill_v | ~ptr_fill);
    grant_fill = fill_v & (~dat_req | ptr_fill);
  end

  // Pointer favours whoever was not granted last.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr_fill <= 1'b0;
    end else if (state == IDLE && (grant_dat | grant_fill)) begin
      ptr_fill <= grant_dat;
    end
  end
`else
  always_comb begin
    grant_dat  = dat_req;
    grant_fill = fill_v & ~dat_req;
  end
`endif

  assign fill_done  = (state == FILL) & last & ~flush;
  assign dat_done   = (state == DATA) & last;
  assign fill_stall = fill_req & ~fill_done & ~flush;
  assign dat_stall  = dat_req & ~dat_done;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dat) begin
            state    <= DATA;
            cnt      <= 4'd0;
            mem_en   <= 1'b1;
            mem_we   <= dat_we;
            mem_addr <= dat_addr;
          end else if (grant_fill) begin
            state    <= FILL;
            cnt      <= 4'd0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
          end
        end
        FILL: begin
          if (flush || last) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DATA: begin
          if (last) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_mem_arb.sv
// Bench for ca_mem_arb: two instances (latency 2 and 1) vs a
// transaction-level reference model; directed steps then random traffic.
module tb_ca_mem_arb;

  localparam int AW = 32;

`ifdef CA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  logic          fr[2], fl[2], dr[2], dw[2];
  logic [AW-1:0] fa[2], da[2];
  logic          men[2], mwe[2], fdn[2], ddn[2], fst[2], dst[2];
  logic [AW-1:0] madr[2];

  // Model: 0 = port free, 1 = fill, 2 = data; left = busy cycles remaining
  int            m_busy[2];
  int            m_left[2];
  logic [AW-1:0] m_addr[2];
  logic          m_we[2];
  logic          m_ptr[2];
  bit            auto_on[2];
  bit            f_fin[2], d_fin[2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ca_mem_arb #(.ADDR_W(AW), .MEM_LATENCY(2)) u0 (
    .clk(clk), .rst_(rst_),
    .fill_req(fr[0]), .fill_addr(fa[0]), .flush(fl[0]),
    .dat_req(dr[0]), .dat_we(dw[0]), .dat_addr(da[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(madr[0]),
    .fill_done(fdn[0]), .dat_done(ddn[0]),
    .fill_stall(fst[0]), .dat_stall(dst[0])
  );

  ca_mem_arb #(.ADDR_W(AW), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_(rst_),
    .fill_req(fr[1]), .fill_addr(fa[1]), .flush(fl[1]),
    .dat_req(dr[1]), .dat_we(dw[1]), .dat_addr(da[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(madr[1]),
    .fill_done(fdn[1]), .dat_done(ddn[1]),
    .fill_stall(fst[1]), .dat_stall(dst[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 0;
    m_left[k] = 0;
    m_addr[k] = '0;
    m_we[k]   = 1'b0;
    m_ptr[k]  = 1'b0;
  endtask

  task automatic check_inst(input int k);
    logic e_fd, e_dd;
    e_fd = (m_busy[k] == 1) && (m_left[k] == 1) && !fl[k];
    e_dd = (m_busy[k] == 2) && (m_left[k] == 1);
    chk($sformatf("mem_en%0d", k), AW'(men[k]), AW'(m_busy[k] != 0));
    chk($sformatf("mem_we%0d", k), AW'(mwe[k]),
        AW'((m_busy[k] == 2) && m_we[k]));
    chk($sformatf("mem_addr%0d", k), madr[k], m_addr[k]);
    chk($sformatf("fill_done%0d", k), AW'(fdn[k]), AW'(e_fd));
    chk($sformatf("dat_done%0d", k), AW'(ddn[k]), AW'(e_dd));
    chk($sformatf("fill_stall%0d", k), AW'(fst[k]),
        AW'(fr[k] && !e_fd && !fl[k]));
    chk($sformatf("dat_stall%0d", k), AW'(dst[k]), AW'(dr[k] && !e_dd));
    chk($sformatf("done_excl%0d", k), AW'(fdn[k] & ddn[k]), '0);
    f_fin[k] = fr[k] && (e_fd || fl[k]);
    d_fin[k] = dr[k] && e_dd;
  endtask

  task automatic advance(input int k);
    bit want_f, want_d, pick_d;
    if (m_busy[k] != 0) begin
      if (m_busy[k] == 1 && fl[k]) m_busy[k] = 0;
      else if (m_left[k] == 1) m_busy[k] = 0;
      else m_left[k]--;
    end else begin
      want_f = fr[k] && !fl[k];
      want_d = dr[k];
      if (want_f || want_d) begin
        if (want_f && want_d) pick_d = RR ? !m_ptr[k] : 1'b1;
        else pick_d = want_d;
        m_busy[k] = pick_d ? 2 : 1;
        m_left[k] = lat(k);
        m_addr[k] = pick_d ? da[k] : fa[k];
        m_we[k]   = pick_d ? dw[k] : 1'b0;
        m_ptr[k]  = pick_d;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_inst(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_) model_reset(k);
      else advance(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (f_fin[k]) fr[k] = 1'b0;
      if (d_fin[k]) dr[k] = 1'b0;
      fl[k] = 1'b0;
      if (auto_on[k]) begin
        if (!fr[k] && $urandom_range(0, 2) == 0) begin
          fr[k] = 1'b1;
          fa[k] = AW'($urandom);
        end
        if (!dr[k] && $urandom_range(0, 2) == 0) begin
          dr[k] = 1'b1;
          dw[k] = 1'($urandom);
          da[k] = AW'($urandom);
        end
        fl[k] = ($urandom_range(0, 9) == 0);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      fr[k] = 1'b0; fl[k] = 1'b0; dr[k] = 1'b0; dw[k] = 1'b0;
      fa[k] = '0;   da[k] = '0;
    end
  endtask

  initial begin
    bit tog;
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      auto_on[k] = 1'b0;
      f_fin[k] = 1'b0;
      d_fin[k] = 1'b0;
    end
    run(2);
    rst_ = 1'b1;
    run(2);

    // fill 0x40
    fr[0] = 1'b1; fa[0] = 32'h40;
    run(5);

    // store 0x100
    dr[0] = 1'b1; dw[0] = 1'b1; da[0] = 32'h100;
    run(5);

    // contention: fill held, data re-requested back to back
    fr[0] = 1'b1; fa[0] = 32'h200;
    dr[0] = 1'b1; dw[0] = 1'b0; da[0] = 32'h300;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!dr[0]) begin
        dr[0] = 1'b1;
        da[0] = da[0] + 32'h4;
      end
    end
    dr[0] = 1'b0;
    run(6);

    // flush in first fill busy cycle with a waiting load
    fr[0] = 1'b1; fa[0] = 32'h80;
    cycle();
    fl[0] = 1'b1;
    dr[0] = 1'b1; dw[0] = 1'b0; da[0] = 32'h500;
    cycle();
    run(5);

    // async reset mid-DATA
    dr[0] = 1'b1; dw[0] = 1'b1; da[0] = 32'h700;
    run(2);
    #2 rst_ = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_en%0d", k), AW'(men[k]), '0);
      chk($sformatf("rst_we%0d", k), AW'(mwe[k]), '0);
      chk($sformatf("rst_addr%0d", k), madr[k], '0);
      chk($sformatf("rst_dd%0d", k), AW'(ddn[k]), '0);
      chk($sformatf("rst_fd%0d", k), AW'(fdn[k]), '0);
      model_reset(k);
    end
    clear_inputs();
    run(2);
    rst_ = 1'b1;
    run(4);

    // latency 1: alternating single requests
    tog = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!fr[1] && !dr[1]) begin
        if (tog) begin
          fr[1] = 1'b1; fa[1] = 32'h1000 + 32'(i);
        end else begin
          dr[1] = 1'b1; dw[1] = 1'(i); da[1] = 32'h2000 + 32'(i);
        end
        tog = !tog;
      end
      cycle();
    end
    run(2);

    // random traffic on both instances
    auto_on[0] = 1'b1;
    auto_on[1] = 1'b1;
    run(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
